// File: rtl/exe_div.sv
// EX-stage DIV/DIVU unit: restoring shift-subtract, one quotient bit per cycle.
// Stalls EX from issue until the cycle the result is valid.
module exe_div (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        cancel_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] part;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] part_nx;
  logic [31:0] dvd_nx;

  always_comb begin
    a_mag = dividend_i;
    b_mag = divisor_i;
    if (signed_i && dividend_i[31]) a_mag = 32'd0 - dividend_i;
    if (signed_i && divisor_i[31])  b_mag = 32'd0 - divisor_i;
    // trial < 2*dvs, so bit 32 of the difference is a clean sign bit
    trial   = {part, dvd[31]};
    diff    = trial - {1'b0, dvs};
    qbit    = ~diff[32];
    part_nx = qbit ? diff[31:0] : trial[31:0];
    dvd_nx  = {dvd[30:0], qbit};
  end

  assign busy_o = !rst_i &&
                  ((state == IDLE && start_i && !cancel_i) ||
                   state == CALC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      dvd    <= 32'd0;
      dvs    <= 32'd0;
      part   <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_o <= 1'b0;
      quot_o <= 32'd0;
      rem_o  <= 32'd0;
    end else begin
      done_o <= 1'b0;
      if (cancel_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              dvd   <= a_mag;
              dvs   <= b_mag;
              part  <= 32'd0;
              cnt   <= 6'd0;
              neg_q <= signed_i &
                       (dividend_i[31] ^ divisor_i[31]);
              neg_r <= signed_i & dividend_i[31];
              if (divisor_i == 32'd0) begin
                quot_o <= 32'hFFFF_FFFF;
                rem_o  <= dividend_i;
                done_o <= 1'b1;
                state  <= DONE;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            dvd  <= dvd_nx;
            part <= part_nx;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              quot_o <= neg_q ? 32'd0 - dvd_nx : dvd_nx;
              rem_o  <= neg_r ? 32'd0 - part_nx : part_nx;
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_div.sv
// Scoreboard bench for exe_div: latency, busy/done timing,
// signed corner cases, cancel and reset aborts.
module tb_exe_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  exe_div dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .signed_i   (sgn),
    .cancel_i   (cancel),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .busy_o     (busy),
    .done_o     (done),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] am, bm, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    am = (s && a[31]) ? 32'd0 - a : a;
    bm = (s && b[31]) ? 32'd0 - b : b;
    q  = am / bm;
    r  = am % bm;
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31]) r = 32'd0 - r;
    return {q, r};
  endfunction

  // result checker: every done pulse must match a queued expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexp_done", {31'd0, done}, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("quot", quot, e[63:32]);
        chk("rem", rem, e[31:0]);
      end
    end
  end

  // Called just after a posedge; returns in the IDLE cycle after DONE.
  task automatic div_op(input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er);
    int lat;
    start    = 1'b1;
    sgn      = s;
    dividend = a;
    divisor  = b;
    sb.push_back({eq, er});
    lat = (b == 32'd0) ? 1 : 33;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk($sformatf("busy@%0d", c), {31'd0, busy},
          {31'd0, c < lat});
      chk($sformatf("done@%0d", c), {31'd0, done},
          {31'd0, c == lat});
      @(posedge clk);
      #1;
      if (c == 0) begin
        dividend = $urandom;
        divisor  = $urandom;
        sgn      = ~s;
      end
    end
    start = 1'b0;
  endtask

  task automatic rand_op;
    logic [31:0] a, b;
    logic        s;
    logic [63:0] e;
    a = $urandom;
    b = $urandom >> $urandom_range(0, 28);
    if (b == 32'd0) b = 32'd5;
    s = 1'($urandom_range(0, 1));
    e = ref_div(s, a, b);
    div_op(s, a, b, e[63:32], e[31:0]);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    sgn      = 1'b0;
    cancel   = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // accepted in the very first cycle out of reset, then back-to-back
    div_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    div_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    div_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    div_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    div_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    div_op(1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    div_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    div_op(1'b0, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3);
    div_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    // cancel at cycle 10, new divide at cycle 12
    start    = 1'b1;
    sgn      = 1'b0;
    dividend = 32'd1000;
    divisor  = 32'd9;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) cancel = 1'b1;
      @(negedge clk);
      chk($sformatf("cbusy@%0d", c), {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    cancel = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_quot", quot, 32'd14);
    chk("cancel_rem", rem, 32'd2);
    @(posedge clk);
    #1;
    div_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // reset asserted in cycle 20 of an operation
    start    = 1'b1;
    sgn      = 1'b1;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd77;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_done", {31'd0, done}, 32'd0);
    chk("rr_quot", quot, 32'd0);
    chk("rr_rem", rem, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) rand_op();

    repeat (40) begin
      @(negedge clk);
      chk("idle_done", {31'd0, done}, 32'd0);
    end
    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
